// File: rtl/pea_invoke_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pea_invoke_ctrl
// Description : Firing controller for the Polynomial Evaluation Accelerator.
//               It pops command and data tokens, runs Horner evaluation and
//               pushes result and status tokens. Define PEA_OVERFLOW_DETECT_EN
//               to report per-point arithmetic overflow in status bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pea_invoke_ctrl #(
    parameter int WORD_SIZE  = 16,
    parameter int COEF_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic [1:0]           next_mode_out,
    output logic [7:0]           mode_out,
    output logic [4:0]           arg2_out,
    input  logic [WORD_SIZE-1:0] command_in,
    output logic                 command_rd_en,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic                 data_rd_en,
    output logic [WORD_SIZE-1:0] result_out,
    output logic                 result_wr_en,
    output logic [WORD_SIZE-1:0] status_out,
    output logic                 status_wr_en,
    output logic                 busy,
    output logic                 cmd_error
);

    localparam logic [7:0] c_MODE_STP = 8'd0;
    localparam logic [7:0] c_MODE_EVP = 8'd1;
    localparam logic [7:0] c_MODE_EVB = 8'd2;
    localparam logic [7:0] c_MODE_RST = 8'd3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_CMD_RD   = 4'd1,
        S_DECODE   = 4'd2,
        S_WAIT_EN  = 4'd3,
        S_STP_RD   = 4'd4,
        S_STP_WR   = 4'd5,
        S_EV_RD    = 4'd6,
        S_EV_LATCH = 4'd7,
        S_HORNER   = 4'd8,
        S_PUSH     = 4'd9
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [7:0]            r_mode;
    logic [4:0]            r_arg2;
    logic                  r_cmd_error;
    logic [4:0]            r_idx;
    logic [4:0]            r_cnt;
    logic [4:0]            r_degree;
    logic [WORD_SIZE-1:0]  r_x;
    logic [WORD_SIZE-1:0]  r_acc;
    logic                  r_first;
    logic [WORD_SIZE-1:0]  r_result;
    logic [WORD_SIZE-1:0]  r_coef [COEF_DEPTH];

    logic                  w_cmd_bad;
    logic                  w_push;
    logic                  w_last_step;
    logic                  w_clear_coef;
    logic [WORD_SIZE-1:0]  w_coef_sel;
    logic [WORD_SIZE-1:0]  w_mac;
    logic [WORD_SIZE-1:0]  w_horner;
    logic                  w_unused_rsvd;

    assign w_cmd_bad     = (command_in[7:0] > 8'd3);
    assign w_unused_rsvd = &{1'b0, command_in[WORD_SIZE-1:13]};

    // First Horner cycle loads c[degree]; later cycles fold in c[idx].
    assign w_coef_sel  = r_first ? r_coef[r_degree] : r_coef[r_idx];
    assign w_mac       = r_acc * r_x + w_coef_sel;
    assign w_horner    = r_first ? w_coef_sel : w_mac;
    assign w_last_step = r_first ? (r_degree == 5'd0) : (r_idx == 5'd0);

    assign w_clear_coef = (r_state == S_WAIT_EN) && enable &&
                          ((r_mode == c_MODE_STP) || (r_mode == c_MODE_RST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        command_rd_en = 1'b0;
        data_rd_en    = 1'b0;
        w_push        = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (enable) begin
                    w_next = S_CMD_RD;
                end
            end
            S_CMD_RD: begin
                command_rd_en = 1'b1;
                w_next        = S_DECODE;
            end
            S_DECODE: begin
                w_next = w_cmd_bad ? S_FETCH : S_WAIT_EN;
            end
            S_WAIT_EN: begin
                if (enable) begin
                    case (r_mode)
                        c_MODE_STP: w_next = S_STP_RD;
                        c_MODE_EVP: w_next = S_EV_RD;
                        c_MODE_EVB: w_next = (r_arg2 == 5'd0) ? S_FETCH : S_EV_RD;
                        default:    w_next = S_FETCH;
                    endcase
                end
            end
            S_STP_RD: begin
                data_rd_en = 1'b1;
                w_next     = S_STP_WR;
            end
            S_STP_WR: begin
                w_next = (r_idx == 5'd0) ? S_PUSH : S_STP_RD;
            end
            S_EV_RD: begin
                data_rd_en = 1'b1;
                w_next     = S_EV_LATCH;
            end
            S_EV_LATCH: begin
                // EVP with zero points still consumes its x token.
                w_next = (r_cnt == 5'd0) ? S_FETCH : S_HORNER;
            end
            S_HORNER: begin
                if (w_last_step) begin
                    w_next = S_PUSH;
                end
            end
            S_PUSH: begin
                w_push = 1'b1;
                if ((r_mode == c_MODE_STP) || (r_cnt == 5'd1)) begin
                    w_next = S_FETCH;
                end else if (r_mode == c_MODE_EVP) begin
                    w_next = S_HORNER;
                end else begin
                    w_next = S_EV_RD;
                end
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode      <= 8'd0;
            r_arg2      <= 5'd0;
            r_cmd_error <= 1'b0;
            r_idx       <= 5'd0;
            r_cnt       <= 5'd0;
            r_x         <= '0;
            r_acc       <= '0;
            r_first     <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_DECODE: begin
                    r_mode <= command_in[7:0];
                    r_arg2 <= command_in[12:8];
                    if (w_cmd_bad) begin
                        r_cmd_error <= 1'b1;
                    end
                end
                S_WAIT_EN: begin
                    r_idx <= r_arg2;
                    r_cnt <= r_arg2;
                end
                S_STP_WR: begin
                    if (r_idx == 5'd0) begin
                        r_result <= {{(WORD_SIZE-5){1'b0}}, r_arg2};
                    end else begin
                        r_idx <= r_idx - 5'd1;
                    end
                end
                S_EV_LATCH: begin
                    r_x     <= data_in;
                    r_first <= 1'b1;
                end
                S_HORNER: begin
                    r_acc   <= w_horner;
                    r_first <= 1'b0;
                    r_idx   <= r_first ? (r_degree - 5'd1) : (r_idx - 5'd1);
                    if (w_last_step) begin
                        r_result <= w_horner;
                    end
                end
                S_PUSH: begin
                    r_cnt   <= r_cnt - 5'd1;
                    r_x     <= r_x + 1'b1;
                    r_first <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // STP zeroes the whole file first so entries above arg2 end up cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < COEF_DEPTH; i++) begin
                r_coef[i] <= '0;
            end
            r_degree <= 5'd0;
        end else if (w_clear_coef) begin
            for (int i = 0; i < COEF_DEPTH; i++) begin
                r_coef[i] <= '0;
            end
            r_degree <= 5'd0;
        end else if (r_state == S_STP_WR) begin
            r_coef[r_idx] <= data_in;
            if (r_idx == 5'd0) begin
                r_degree <= r_arg2;
            end
        end
    end

`ifdef PEA_OVERFLOW_DETECT_EN
    logic [2*WORD_SIZE-1:0] w_prod;
    logic [WORD_SIZE:0]     w_sum;
    logic                   w_step_ovf;
    logic                   r_ovf;
    logic [WORD_SIZE-1:0]   r_status;

    assign w_prod     = {{WORD_SIZE{1'b0}}, r_acc} * {{WORD_SIZE{1'b0}}, r_x};
    assign w_sum      = {1'b0, w_prod[WORD_SIZE-1:0]} + {1'b0, w_coef_sel};
    assign w_step_ovf = (|w_prod[2*WORD_SIZE-1:WORD_SIZE]) | w_sum[WORD_SIZE];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf    <= 1'b0;
            r_status <= '0;
        end else if (r_state == S_HORNER) begin
            r_ovf <= r_first ? 1'b0 : (r_ovf | w_step_ovf);
            if (w_last_step) begin
                r_status <= {{(WORD_SIZE-1){1'b0}}, (~r_first) & (r_ovf | w_step_ovf)};
            end
        end else if ((r_state == S_STP_WR) && (r_idx == 5'd0)) begin
            r_status <= '0;
        end
    end

    assign status_out = r_status;
`else
    assign status_out = '0;
`endif

    assign next_mode_out = ((r_state == S_FETCH) || (r_state == S_CMD_RD)) ? 2'b00 : 2'b01;
    assign busy          = (r_state != S_FETCH);
    assign mode_out      = r_mode;
    assign arg2_out      = r_arg2;
    assign cmd_error     = r_cmd_error;
    assign result_out    = r_result;
    assign result_wr_en  = w_push;
    assign status_wr_en  = w_push;

endmodule
`default_nettype wire
